// File: rtl/rf_pkg.sv
// Shared constants for the integer register file, its pending-write scoreboard, and the decode/write-back opcode agreement.
package rf_pkg;
   localparam int RFW  = 5;
   localparam int DW   = 32;
   localparam int NREG = 32;
   localparam int CNTW = 2;

   localparam logic [RFW-1:0]  REG_ZERO = '0;
   localparam logic [CNTW-1:0] CNT_MAX  = '1;

   localparam logic [6:0] OP_R = 7'h33;
   localparam logic [6:0] OP_I = 7'h13;

   // Decode uses this to raise issue_valid, and write-back uses it to raise rf_we.
   function automatic logic writes_rd(input logic [6:0] opcode);
      return (opcode == OP_R) || (opcode == OP_I);
   endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters: issue increments, write-back retirement decrements; issue_ready/busy are combinational.
// An issue is blocked while the destination counter is at max, so the counters saturate by construction.
module rf_scoreboard
   import rf_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           rf_we,
   input  logic [RFW-1:0] wreg,
   input  logic           issue_valid,
   input  logic [RFW-1:0] issue_rd,
   input  logic [RFW-1:0] raddr1,
   input  logic [RFW-1:0] raddr2,
   output logic           issue_ready,
   output logic           busy1,
   output logic           busy2
);
   logic [CNTW-1:0] cnt_q [NREG];
   logic [CNTW-1:0] cnt_d [NREG];
   logic            inc;
   logic            dec;
   logic [CNTW-1:0] cnt1;
   logic [CNTW-1:0] cnt2;
   logic            land1;
   logic            land2;

   // Readiness looks only at the current count; a same-cycle retirement does not free a slot.
   assign issue_ready = !rst && ((issue_rd == REG_ZERO) || (cnt_q[issue_rd] != CNT_MAX));
   assign inc         = issue_valid && issue_ready && (issue_rd != REG_ZERO);
   assign dec         = rf_we && (wreg != REG_ZERO) && (cnt_q[wreg] != '0);

   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         cnt_d[i] = cnt_q[i];
         if (inc && (issue_rd == RFW'(i)) && !(dec && (wreg == RFW'(i)))) begin
            cnt_d[i] = cnt_q[i] + CNTW'(1);
         end else if (dec && (wreg == RFW'(i)) && !(inc && (issue_rd == RFW'(i)))) begin
            cnt_d[i] = cnt_q[i] - CNTW'(1);
         end
      end
      cnt_d[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A write landing this cycle satisfies one outstanding write; same-cycle issues are ignored.
   assign cnt1  = cnt_q[raddr1];
   assign cnt2  = cnt_q[raddr2];
   assign land1 = rf_we && (wreg == raddr1) && (cnt1 != '0);
   assign land2 = rf_we && (wreg == raddr2) && (cnt2 != '0);
   assign busy1 = !rst && (raddr1 != REG_ZERO) && ((cnt1 - CNTW'(land1)) != '0);
   assign busy2 = !rst && (raddr2 != REG_ZERO) && ((cnt2 - CNTW'(land2)) != '0);
endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file: one write-back port, two combinational read ports with write-through bypass, plus RAW scoreboard.
// Reads have zero latency; decode stalls on busy1/busy2 and holds issue_valid until issue_ready.
module reg_file_wb
   import rf_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           rf_we,
   input  logic [RFW-1:0] wreg,
   input  logic [DW-1:0]  wdata,
   input  logic [RFW-1:0] raddr1,
   input  logic [RFW-1:0] raddr2,
   output logic [DW-1:0]  rdata1,
   output logic [DW-1:0]  rdata2,
   output logic           busy1,
   output logic           busy2,
   input  logic           issue_valid,
   input  logic [RFW-1:0] issue_rd,
   output logic           issue_ready
);
   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] regs_d [NREG];

   // x0 writes are dropped here as well, so its storage stays zero regardless of upstream behaviour.
   always_comb begin
      regs_d = regs_q;
      if (rf_we && (wreg != REG_ZERO)) begin
         regs_d[wreg] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rdata1 = '0;
      if (!rst && (raddr1 != REG_ZERO)) begin
         rdata1 = (rf_we && (wreg == raddr1)) ? wdata : regs_q[raddr1];
      end
   end

   always_comb begin
      rdata2 = '0;
      if (!rst && (raddr2 != REG_ZERO)) begin
         rdata2 = (rf_we && (wreg == raddr2)) ? wdata : regs_q[raddr2];
      end
   end

   rf_scoreboard u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .rf_we       (rf_we),
      .wreg        (wreg),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .raddr1      (raddr1),
      .raddr2      (raddr2),
      .issue_ready (issue_ready),
      .busy1       (busy1),
      .busy2       (busy2)
   );
endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed scenarios plus randomized traffic against a behavioural model.
module tb_reg_file_wb;
   logic        clk;
   logic        rst;
   logic        rf_we;
   logic [4:0]  wreg;
   logic [31:0] wdata;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   logic        busy1;
   logic        busy2;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_ready;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: register contents and number of outstanding writes per register.
   bit [31:0] m_reg [32];
   int        m_cnt [32];

   reg_file_wb dut (
      .clk         (clk),
      .rst         (rst),
      .rf_we       (rf_we),
      .wreg        (wreg),
      .wdata       (wdata),
      .raddr1      (raddr1),
      .raddr2      (raddr2),
      .rdata1      (rdata1),
      .rdata2      (rdata2),
      .busy1       (busy1),
      .busy2       (busy2),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] exp_rdata(input logic [4:0] a);
      if (rst || a == 5'd0) return 32'h0;
      if (rf_we && wreg == a) return wdata;
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      int pending;
      if (rst || a == 5'd0) return 1'b0;
      pending = m_cnt[a];
      if (rf_we && wreg == a && pending > 0) pending = pending - 1;
      return pending > 0;
   endfunction

   function automatic logic exp_ready();
      if (rst) return 1'b0;
      return (issue_rd == 5'd0) || (m_cnt[issue_rd] < 3);
   endfunction

   // Advance the model by one clock with the inputs currently driven, then step the DUT.
   task automatic tick();
      bit acc;
      bit ret;
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_reg[i] = 32'h0;
            m_cnt[i] = 0;
         end
      end else begin
         acc = issue_valid && exp_ready() && issue_rd != 5'd0;
         ret = rf_we && wreg != 5'd0 && m_cnt[wreg] > 0;
         if (rf_we && wreg != 5'd0) m_reg[wreg] = wdata;
         if (acc) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
         if (ret) m_cnt[wreg] = m_cnt[wreg] - 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rf_we = 1'b1; wreg = 5'd5; wdata = $urandom | 32'h1;
      issue_valid = 1'b1; issue_rd = 5'd5; raddr1 = 5'd5; raddr2 = 5'd31;
      repeat (2) begin
         @(negedge clk);
         n_vec++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL reset_rdata1 got %h want 0", rdata1); end
         n_vec++; if (rdata2 !== 32'h0) begin n_err++; $display("FAIL reset_rdata2 got %h want 0", rdata2); end
         n_vec++; if ({busy1, busy2} !== 2'b00) begin n_err++; $display("FAIL reset_busy got %b%b want 00", busy1, busy2); end
         n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", issue_ready); end
         tick();
      end
      rst = 1'b0; rf_we = 1'b0; issue_valid = 1'b0;
      @(negedge clk);
      n_vec++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL post_reset_rdata1 got %h want 0", rdata1); end
      n_vec++; if (rdata2 !== 32'h0) begin n_err++; $display("FAIL post_reset_rdata2 got %h want 0", rdata2); end
      n_vec++; if ({busy1, busy2} !== 2'b00) begin n_err++; $display("FAIL post_reset_busy got %b%b want 00", busy1, busy2); end
      n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b want 1", issue_ready); end
      tick();
   endtask

   task automatic test_x0_write();
      rf_we = 1'b1; wreg = 5'd0; wdata = 32'hDEADBEEF; raddr1 = 5'd0;
      issue_valid = 1'b1; issue_rd = 5'd0;
      @(negedge clk);
      n_vec++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL x0_same_cycle got %h want 0", rdata1); end
      n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready got %b want 1", issue_ready); end
      tick();
      rf_we = 1'b0; issue_valid = 1'b0;
      @(negedge clk);
      n_vec++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL x0_next_cycle got %h want 0", rdata1); end
      n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL x0_busy got %b want 0", busy1); end
      tick();
   endtask

   task automatic test_bypass();
      rf_we = 1'b1; wreg = 5'd3; wdata = 32'h12345678; raddr1 = 5'd3;
      @(negedge clk);
      n_vec++; if (rdata1 !== 32'h12345678) begin n_err++; $display("FAIL bypass_same got %h want 12345678", rdata1); end
      tick();
      rf_we = 1'b0; wdata = 32'h0;
      @(negedge clk);
      n_vec++; if (rdata1 !== 32'h12345678) begin n_err++; $display("FAIL bypass_stored got %h want 12345678", rdata1); end
      tick();
   endtask

   task automatic test_busy_landing();
      logic [31:0] d;
      d = $urandom;
      issue_valid = 1'b1; issue_rd = 5'd7; raddr2 = 5'd7;
      @(negedge clk);
      n_vec++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL busy_self_issue got %b want 0", busy2); end
      tick();
      issue_valid = 1'b0;
      @(negedge clk);
      n_vec++; if (busy2 !== 1'b1) begin n_err++; $display("FAIL busy_pending got %b want 1", busy2); end
      tick();
      rf_we = 1'b1; wreg = 5'd7; wdata = d;
      @(negedge clk);
      n_vec++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL busy_landing got %b want 0", busy2); end
      n_vec++; if (rdata2 !== d) begin n_err++; $display("FAIL landing_data got %h want %h", rdata2, d); end
      tick();
      rf_we = 1'b0;
      @(negedge clk);
      n_vec++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL busy_after_land got %b want 0", busy2); end
      tick();
   endtask

   task automatic test_saturation();
      logic [31:0] d;
      raddr1 = 5'd9; issue_rd = 5'd9; issue_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL sat_fill%0d_ready got %b want 1", k, issue_ready); end
         tick();
      end
      @(negedge clk);
      n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL sat_full_ready got %b want 0", issue_ready); end
      n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL sat_full_busy got %b want 1", busy1); end
      tick();
      issue_valid = 1'b0; rf_we = 1'b1; wreg = 5'd9; wdata = $urandom;
      @(negedge clk);
      n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL sat_dec_same_ready got %b want 0", issue_ready); end
      tick();
      rf_we = 1'b0;
      @(negedge clk);
      n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL sat_after_dec_ready got %b want 1", issue_ready); end
      tick();
      issue_valid = 1'b1; rf_we = 1'b1; wdata = $urandom;
      tick();
      issue_valid = 1'b0; wdata = $urandom;
      @(negedge clk);
      n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL sat_cnt2_busy got %b want 1", busy1); end
      tick();
      d = $urandom; wdata = d;
      @(negedge clk);
      n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL sat_last_land_busy got %b want 0", busy1); end
      tick();
      rf_we = 1'b0;
      @(negedge clk);
      n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL sat_drained_busy got %b want 0", busy1); end
      n_vec++; if (rdata1 !== d) begin n_err++; $display("FAIL sat_drained_data got %h want %h", rdata1, d); end
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         rst = ($urandom_range(0, 99) < 2);
         rf_we = $urandom_range(0, 1);
         wreg = 5'($urandom_range(0, 7));
         wdata = $urandom;
         issue_valid = $urandom_range(0, 1);
         issue_rd = 5'($urandom_range(0, 7));
         raddr1 = 5'($urandom_range(0, 7));
         raddr2 = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
         @(negedge clk);
         n_vec++; if (rdata1 !== exp_rdata(raddr1)) begin n_err++; $display("FAIL rand_rdata1 c%0d got %h want %h", c, rdata1, exp_rdata(raddr1)); end
         n_vec++; if (rdata2 !== exp_rdata(raddr2)) begin n_err++; $display("FAIL rand_rdata2 c%0d got %h want %h", c, rdata2, exp_rdata(raddr2)); end
         n_vec++; if (busy1 !== exp_busy(raddr1)) begin n_err++; $display("FAIL rand_busy1 c%0d got %b want %b", c, busy1, exp_busy(raddr1)); end
         n_vec++; if (busy2 !== exp_busy(raddr2)) begin n_err++; $display("FAIL rand_busy2 c%0d got %b want %b", c, busy2, exp_busy(raddr2)); end
         n_vec++; if (issue_ready !== exp_ready()) begin n_err++; $display("FAIL rand_ready c%0d got %b want %b", c, issue_ready, exp_ready()); end
         tick();
      end
      rst = 1'b0; rf_we = 1'b0; issue_valid = 1'b0;
   endtask

   task automatic test_reset_midflight();
      logic [31:0] d4;
      logic [31:0] d6;
      d4 = $urandom | 32'h1; d6 = $urandom | 32'h1;
      rst = 1'b1; rf_we = 1'b0; issue_valid = 1'b0;
      tick();
      rst = 1'b0; rf_we = 1'b1; wreg = 5'd4; wdata = d4;
      tick();
      wreg = 5'd6; wdata = d6;
      tick();
      rf_we = 1'b0; issue_valid = 1'b1; issue_rd = 5'd4;
      tick();
      issue_rd = 5'd6;
      tick();
      issue_valid = 1'b0; raddr1 = 5'd4; raddr2 = 5'd6;
      @(negedge clk);
      n_vec++; if ({busy1, busy2} !== 2'b11) begin n_err++; $display("FAIL mid_pending_busy got %b%b want 11", busy1, busy2); end
      n_vec++; if (rdata1 !== d4 || rdata2 !== d6) begin n_err++; $display("FAIL mid_data got %h %h want %h %h", rdata1, rdata2, d4, d6); end
      tick();
      rst = 1'b1; rf_we = 1'b1; wreg = 5'd4; wdata = $urandom | 32'h1; issue_valid = 1'b1;
      tick();
      rst = 1'b0; rf_we = 1'b0; issue_valid = 1'b0; issue_rd = 5'd4;
      @(negedge clk);
      n_vec++; if ({busy1, busy2} !== 2'b00) begin n_err++; $display("FAIL mid_reset_busy got %b%b want 00", busy1, busy2); end
      n_vec++; if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin n_err++; $display("FAIL mid_reset_data got %h %h want 0 0", rdata1, rdata2); end
      n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_ready got %b want 1", issue_ready); end
      tick();
   endtask

   initial begin
      rst = 1'b1; rf_we = 1'b0; wreg = '0; wdata = '0;
      raddr1 = '0; raddr2 = '0; issue_valid = 1'b0; issue_rd = '0;
      #1;
      test_reset();
      test_x0_write();
      test_bypass();
      test_busy_landing();
      test_saturation();
      test_random();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Architectural integer register file that receives the write-back stage's write port (rf_we, wreg, wdata).
- Provides two read ports to decode, with same-cycle write-through bypass.
- Holds a per-register pending-write scoreboard. Decode marks a destination at issue; write-back clears it on retirement.
- Decode uses the busy flags to stall on RAW hazards.

Parameters:
- RFW, 5, register index width.
- DW, 32, data width.
- NREG, 32, number of registers (must equal 2**RFW).
- CNTW, 2, width of each per-register pending-write counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- rf_we  in  1  write enable from write-back.
- wreg  in  RFW  write register index.
- wdata  in  DW  write data.
- raddr1  in  RFW  read port 1 index.
- raddr2  in  RFW  read port 2 index.
- rdata1  out  DW  read port 1 data (combinational).
- rdata2  out  DW  read port 2 data (combinational).
- busy1  out  1  raddr1 has an outstanding write not satisfied this cycle.
- busy2  out  1  raddr2 has an outstanding write not satisfied this cycle.
- issue_valid  in  1  decode issues an instruction that writes issue_rd.
- issue_rd  in  RFW  destination of the issuing instruction.
- issue_ready  out  1  the scoreboard can accept issue_rd.

Behaviour:
- Reset: clk and rst as above; one clock domain; reset is synchronous and active-high.
  - While rst=1 at a rising edge, all NREG registers are set to 0 and all pending counters are set to 0.
  - While rst is asserted, rdata1/rdata2=0, busy1/busy2=0 and issue_ready=0.
  - Reset asserted mid-operation discards all pending state. A write or issue presented in the same cycle as reset is ignored.
- Write:
  - At the clock edge, if rf_we=1 and wreg!=0, then reg[wreg]<=wdata.
  - Writes to x0 are dropped, even though write-back already suppresses them.
- Read (combinational, 0 latency):
  - rdataN=0 if raddrN==0.
  - Otherwise, if rf_we=1 and wreg==raddrN, rdataN=wdata (write-through bypass).
  - Otherwise rdataN=reg[raddrN].
- Scoreboard: one CNTW-bit counter cnt[i] per register; cnt[0] stays 0 permanently.
  - inc = issue_valid & issue_ready & (issue_rd!=0).
  - dec = rf_we & (wreg!=0) & (cnt[wreg]!=0).
  - inc and dec on the same register in the same cycle leave the count unchanged.
  - Otherwise inc adds 1 and dec subtracts 1.
  - A writeback to a register whose count is 0 still updates data; the counter does not underflow.
- issue_ready:
  - = (issue_rd==0) | (cnt[issue_rd] != 2**CNTW-1).
  - If issue_ready=0, the issue is ignored. Decode holds issue_valid and stalls until it rises.
  - A same-cycle dec to issue_rd does not raise issue_ready; issue_ready is based on the current count only.
- busyN:
  - = (raddrN!=0) & (cnt[raddrN] - (rf_we & wreg==raddrN & cnt[raddrN]!=0 ? 1 : 0) != 0).
  - The last outstanding write landing this cycle is bypassed and is not busy.
  - busyN ignores a same-cycle issue, so an instruction never depends on itself.
- Arithmetic:
  - All counters are unsigned and saturate by construction, because inc is blocked at max.
  - Data has no width conversion.
- No other sequential outputs. All outputs are combinational from state and inputs.

Decomposition:
- Shared package rf_pkg:
  - RFW, DW, NREG, CNTW constants.
  - REG_ZERO=0 constant.
  - Opcode constants OP_R=7'h33 and OP_I=7'h13, so decode's issue logic and write-back agree on which instructions write a register.
- One natural sub-module: rf_scoreboard.
  - Holds the counter array, inc/dec logic, issue_ready, and raw busy flags.
  - reg_file_wb keeps the storage array and the bypass muxes.

Test Plan:
- Reset: hold rst 2 cycles, then read raddr1=5, raddr2=31. Expect rdata=0, busy=0. issue_ready=0 during reset, 1 after.
- x0 write: rf_we=1, wreg=0, wdata=32'hDEADBEEF, then raddr1=0. Expect rdata1=0 on the same and the next cycle. cnt[0] never changes.
- Bypass:
  - Write wreg=3, wdata=32'h12345678 while raddr1=3. Expect rdata1=32'h12345678 in the same cycle.
  - Next cycle, with rf_we=0, rdata1 still reads 32'h12345678.
- Busy clears on landing:
  - Issue rd=7, then hold raddr2=7. Expect busy2=1.
  - When the writeback to 7 arrives, busy2=0 in that cycle and rdata2=wdata.
- Saturation:
  - Issue rd=9 three times. Expect issue_ready=0 for rd=9.
  - A 4th issue is ignored and cnt stays at 3.
  - One writeback to 9 gives issue_ready=1 the next cycle.
  - Simultaneous issue and writeback to 9 with cnt=2 leaves cnt=2.
- Reset mid-flight: issue rd=4 and rd=6, then assert rst. Expect busy=0 for 4 and 6, and rdata=0 for both after reset.
